// File: rtl/microcode_sequencer.sv
// Next-state sequencer for the microprogrammed control unit; holds the microstore address.
// Latency: one cycle; inputs sampled in a cycle appear as the new state after its rising edge.
// Backpressure: WAIT with moc low holds the state for up to TIMEOUT cycles, then halts in FAULT_STATE.
module microcode_sequencer #(
   parameter int                 STATE_W     = 10,
   parameter logic [STATE_W-1:0] RESET_STATE = 10'd0,
   parameter logic [STATE_W-1:0] FETCH_STATE = 10'd1,
   parameter logic [STATE_W-1:0] FAULT_STATE = 10'd1023,
   parameter int                 TIMEOUT     = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [STATE_W-1:0] encoded_state,
   input  logic [2:0]         next_sel,
   input  logic [STATE_W-1:0] jump_addr,
   input  logic               cond_pass,
   input  logic               moc,
   output logic [STATE_W-1:0] state,
   output logic               wait_active,
   output logic               mem_fault,
   output logic               illegal_op
);

   typedef enum logic [2:0] {
      SEL_INC    = 3'b000,
      SEL_JUMP   = 3'b001,
      SEL_DECODE = 3'b010,
      SEL_FETCH  = 3'b011,
      SEL_CJUMP  = 3'b100,
      SEL_WAIT   = 3'b101
   } sel_e;

   // Last count value at which a still-low moc turns into a timeout.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [STATE_W-1:0] state_nxt;
   logic [STATE_W-1:0] state_inc;
   logic [7:0]         wait_cnt;
   logic [7:0]         wait_cnt_nxt;
   logic               set_mem_fault;
   logic               set_illegal_op;
   logic               in_fault;

   assign state_inc = state + STATE_W'(1);
   assign in_fault  = (state == FAULT_STATE);

   // Registered state, wait counter and sticky fault flags; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RESET_STATE;
         wait_cnt   <= 8'd0;
         mem_fault  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (set_mem_fault)  mem_fault  <= 1'b1;
         if (set_illegal_op) illegal_op <= 1'b1;
      end
   end

   // Next-state selection; the counter only survives a cycle that holds in WAIT.
   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = 8'd0;
      set_mem_fault  = 1'b0;
      set_illegal_op = 1'b0;
      wait_active    = 1'b0;
      if (in_fault) begin
         // Absorbing: only reset leaves the fault state.
         state_nxt = FAULT_STATE;
      end else begin
         case (next_sel)
            SEL_INC:  state_nxt = state_inc;
            SEL_JUMP: state_nxt = jump_addr;
            SEL_DECODE: begin
               if (!cond_pass) begin
                  state_nxt = FETCH_STATE;
               end else if (encoded_state == '0) begin
                  state_nxt      = FAULT_STATE;
                  set_illegal_op = 1'b1;
               end else begin
                  state_nxt = encoded_state;
               end
            end
            SEL_FETCH: state_nxt = FETCH_STATE;
            SEL_CJUMP: state_nxt = cond_pass ? jump_addr : state_inc;
            SEL_WAIT: begin
               wait_active = !moc;
               if (moc) begin
                  // moc wins even on the timeout cycle.
                  state_nxt = state_inc;
               end else if (wait_cnt == WAIT_LAST) begin
                  state_nxt     = FAULT_STATE;
                  set_mem_fault = 1'b1;
               end else begin
                  state_nxt    = state;
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
            // Reserved selectors fall back to instruction fetch without flagging.
            default: state_nxt = FETCH_STATE;
         endcase
      end
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

   localparam int STATE_W = 10;
   localparam logic [2:0] INC = 3'b000, JMP = 3'b001, DEC = 3'b010, FET = 3'b011,
                          CJ = 3'b100, WT = 3'b101, R6 = 3'b110, R7 = 3'b111;

   logic               clk = 1'b0;
   logic               reset;
   logic [STATE_W-1:0] encoded_state;
   logic [2:0]         next_sel;
   logic [STATE_W-1:0] jump_addr;
   logic               cond_pass;
   logic               moc;
   logic [STATE_W-1:0] state;
   logic               wait_active;
   logic               mem_fault;
   logic               illegal_op;

   int checks = 0;
   int errors = 0;
   int wa_high = 0;

   always #5 clk = ~clk;

   microcode_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .encoded_state (encoded_state),
      .next_sel      (next_sel),
      .jump_addr     (jump_addr),
      .cond_pass     (cond_pass),
      .moc           (moc),
      .state         (state),
      .wait_active   (wait_active),
      .mem_fault     (mem_fault),
      .illegal_op    (illegal_op)
   );

   typedef struct {
      string              name;
      logic               rst;
      logic [2:0]         sel;
      logic [STATE_W-1:0] ja;
      logic [STATE_W-1:0] enc;
      logic               cp;
      logic               mo;
      logic [STATE_W-1:0] exp_state;
      logic               exp_wa;
      logic               exp_mf;
      logic               exp_io;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic rst, input logic [2:0] sel,
                      input int ja, input int enc, input logic cp, input logic mo,
                      input int es, input logic wa, input logic mf, input logic io);
      vec_t v;
      v.name = name; v.rst = rst; v.sel = sel; v.ja = ja[STATE_W-1:0];
      v.enc = enc[STATE_W-1:0]; v.cp = cp; v.mo = mo; v.exp_state = es[STATE_W-1:0];
      v.exp_wa = wa; v.exp_mf = mf; v.exp_io = io;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one cycle: check wait_active before the edge, state and flags after it.
   task automatic step(input string name, input logic rst, input logic [2:0] sel,
                       input int ja, input int enc, input logic cp, input logic mo,
                       input int es, input logic wa, input logic mf, input logic io);
      reset = rst; next_sel = sel; jump_addr = ja[STATE_W-1:0];
      encoded_state = enc[STATE_W-1:0]; cond_pass = cp; moc = mo;
      #1;
      chk({name, ".wait_active"}, int'(wait_active), int'(wa));
      if (wait_active) wa_high++;
      @(posedge clk);
      #1;
      chk({name, ".state"}, int'(state), es);
      chk({name, ".mem_fault"}, int'(mem_fault), int'(mf));
      chk({name, ".illegal_op"}, int'(illegal_op), int'(io));
   endtask

   task automatic wt(input string name, input logic mo, input int es, input logic mf);
      step(name, 1'b0, WT, 0, 0, 1'b0, mo, es, !mo && (state != 1023), mf, 1'b0);
   endtask

   initial begin
      //    name          rst sel  ja    enc cp mo  state wa mf io
      add("reset",        1, INC, 0,    0,  0, 0,  0,    0, 0, 0);
      add("inc0",         0, INC, 0,    0,  0, 0,  1,    0, 0, 0);
      add("jump1",        0, JMP, 1,    0,  0, 0,  1,    0, 0, 0);
      add("inc1",         0, INC, 1,    0,  0, 0,  2,    0, 0, 0);
      add("rst_mid",      1, INC, 0,    0,  0, 0,  0,    0, 0, 0);
      add("jump4a",       0, JMP, 4,    0,  0, 0,  4,    0, 0, 0);
      add("dec_ok",       0, DEC, 0,    20, 1, 0,  20,   0, 0, 0);
      add("jump4b",       0, JMP, 4,    0,  0, 0,  4,    0, 0, 0);
      add("dec_nocond",   0, DEC, 0,    20, 0, 0,  1,    0, 0, 0);
      add("jump10a",      0, JMP, 10,   0,  0, 0,  10,   0, 0, 0);
      add("cjump_taken",  0, CJ,  40,   0,  1, 0,  40,   0, 0, 0);
      add("jump10b",      0, JMP, 10,   0,  0, 0,  10,   0, 0, 0);
      add("cjump_not",    0, CJ,  40,   0,  0, 0,  11,   0, 0, 0);
      add("rsv110",       0, R6,  40,   0,  1, 1,  1,    0, 0, 0);
      add("jump5",        0, JMP, 5,    0,  0, 0,  5,    0, 0, 0);
      add("rsv111",       0, R7,  40,   0,  1, 1,  1,    0, 0, 0);
      add("jump7",        0, JMP, 7,    0,  0, 0,  7,    0, 0, 0);
      add("fetch",        0, FET, 7,    0,  1, 0,  1,    0, 0, 0);
      add("jump1022",     0, JMP, 1022, 0,  0, 0,  1022, 0, 0, 0);
      add("inc_wrap",     0, INC, 0,    0,  0, 0,  1023, 0, 0, 0);
      add("halt_jump",    0, JMP, 5,    0,  0, 0,  1023, 0, 0, 0);
      add("halt_wait",    0, WT,  0,    0,  0, 0,  1023, 0, 0, 0);
      add("rst_halt",     1, JMP, 5,    0,  0, 0,  0,    0, 0, 0);
      add("jump4c",       0, JMP, 4,    0,  0, 0,  4,    0, 0, 0);
      add("dec_illegal",  0, DEC, 0,    0,  1, 0,  1023, 0, 0, 1);
      add("ill_inc",      0, INC, 0,    0,  0, 0,  1023, 0, 0, 1);
      add("ill_jump",     0, JMP, 3,    0,  0, 0,  1023, 0, 0, 1);
      add("ill_dec",      0, DEC, 0,    5,  1, 0,  1023, 0, 0, 1);
      add("ill_cjump",    0, CJ,  9,    0,  1, 1,  1023, 0, 0, 1);
      add("rst_ill",      1, INC, 0,    0,  0, 0,  0,    0, 0, 0);

      reset = 1'b1; next_sel = INC; jump_addr = '0; encoded_state = '0;
      cond_pass = 1'b0; moc = 1'b0;

      foreach (vecs[i])
         step(vecs[i].name, vecs[i].rst, vecs[i].sel, int'(vecs[i].ja), int'(vecs[i].enc),
              vecs[i].cp, vecs[i].mo, int'(vecs[i].exp_state), vecs[i].exp_wa,
              vecs[i].exp_mf, vecs[i].exp_io);

      // Short wait: three low cycles then moc.
      step("w3_jump", 0, JMP, 2, 0, 0, 0, 2, 0, 0, 0);
      wa_high = 0;
      for (int i = 0; i < 3; i++) wt("w3_low", 1'b0, 2, 1'b0);
      wt("w3_moc", 1'b1, 3, 1'b0);
      chk("w3_wa_cycles", wa_high, 3);

      // Full timeout: 15 cycles at state 2, then halt with mem_fault.
      step("to_jump", 0, JMP, 2, 0, 0, 0, 2, 0, 0, 0);
      for (int i = 0; i < 14; i++) wt("to_low", 1'b0, 2, 1'b0);
      wt("to_expire", 1'b0, 1023, 1'b1);
      wt("to_halt_moc", 1'b1, 1023, 1'b1);
      step("to_halt_inc", 0, INC, 0, 0, 1, 1, 1023, 0, 1, 0);
      step("to_reset", 1, WT, 0, 0, 0, 0, 0, 0, 0, 0);

      // moc arriving exactly on the last permitted cycle wins.
      step("edge_jump", 0, JMP, 2, 0, 0, 0, 2, 0, 0, 0);
      for (int i = 0; i < 14; i++) wt("edge_low", 1'b0, 2, 1'b0);
      wt("edge_moc", 1'b1, 3, 1'b0);

      // Back-to-back waits of 10 low cycles each; counter must restart.
      step("b2b_jump", 0, JMP, 2, 0, 0, 0, 2, 0, 0, 0);
      for (int i = 0; i < 10; i++) wt("b2b_low1", 1'b0, 2, 1'b0);
      wt("b2b_moc1", 1'b1, 3, 1'b0);
      for (int i = 0; i < 10; i++) wt("b2b_low2", 1'b0, 3, 1'b0);
      wt("b2b_moc2", 1'b1, 4, 1'b0);

      // Reset mid-wait clears the counter as well as the state.
      step("rw_jump", 0, JMP, 2, 0, 0, 0, 2, 0, 0, 0);
      for (int i = 0; i < 8; i++) wt("rw_low", 1'b0, 2, 1'b0);
      step("rw_reset", 1, WT, 0, 0, 0, 0, 0, 1, 0, 0);
      step("rw_jump2", 0, JMP, 2, 0, 0, 0, 2, 0, 0, 0);
      for (int i = 0; i < 14; i++) wt("rw_low2", 1'b0, 2, 1'b0);
      wt("rw_moc", 1'b1, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
